// File: rtl/icache.sv
// icache: direct-mapped, blocking instruction cache with single-line refill over a req/resp handshake.
// Optional feature: define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache #(
  parameter int ARCH_LEN   = 32,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ARCH_LEN-1:0]     req_addr,
  input  logic                    kill,
  output logic                    resp_valid,
  output logic [ARCH_LEN-1:0]     resp_inst,
  output logic                    stall_out,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ARCH_LEN-1:0]     mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [8*LINE_BYTES-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ARCH_LEN - OFF_W - IDX_W;
  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [1:0] {LOOKUP, REQ, WAIT, FILL} state_t;

  state_t                     state;
  logic [NUM_LINES-1:0]       valid;
  logic [TAG_W-1:0]           tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]          data_mem [NUM_LINES];
  logic [ARCH_LEN-OFF_W-1:0]  line_addr;
  logic                       killed;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  word_off;
  logic [LINE_W-1:0] req_line;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup;
  logic              hit;
  logic              miss;
  logic              fill_now;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ARCH_LEN-1 -: TAG_W];
  assign word_off = req_addr[OFF_W-1:0] & ~OFF_W'(3);
  assign req_line = data_mem[req_idx];
  assign fill_idx = line_addr[IDX_W-1:0];
  assign fill_tag = line_addr[ARCH_LEN-OFF_W-1 -: TAG_W];

  // A killed lookup neither hits nor starts a miss.
  assign lookup   = (state == LOOKUP) && req_valid && !kill;
  assign hit      = lookup && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign miss     = lookup && !hit;
  assign fill_now = (state == WAIT) && mem_resp_valid && !rst;

  assign resp_valid    = hit;
  assign resp_inst     = hit ? req_line[{word_off, 3'b000} +: ARCH_LEN] : '0;
  assign stall_out     = miss || (state != LOOKUP);
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = mem_req_valid ? {line_addr, {OFF_W{1'b0}}} : '0;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOOKUP;
      valid     <= '0;
      line_addr <= '0;
      killed    <= 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          if (miss) begin
            line_addr <= req_addr[ARCH_LEN-1:OFF_W];
            killed    <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (kill) killed <= 1'b1;
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (kill) killed <= 1'b1;
          if (mem_resp_valid) begin
            valid[fill_idx] <= 1'b1;
            // An abandoned refill still installs the line but skips the replay cycle.
            state <= (killed || kill) ? LOOKUP : FILL;
          end
        end
        FILL:    state <= LOOKUP;
        default: state <= LOOKUP;
      endcase
    end
  end

  // NOTE: line data and tags are not reset; the valid bits alone decide whether a line can hit.
  always_ff @(posedge clk) begin
    if (fill_now) begin
      data_mem[fill_idx] <= mem_resp_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
